// File: rtl/acc_src_select.sv
// acc_src_select: registered accumulator source select.
// Captures one of NUM_INPUTS sources into the accumulator on a load request.
// A load on a source that is not yet valid parks in WAIT until the source
// becomes valid or TIMEOUT cycles pass.
//
// Ports:
//   clk, reset    rising-edge clock, synchronous active-high reset
//   src_bus       flattened sources; source i = [i*DATA_WIDTH +: DATA_WIDTH]
//   src_valid     per-source valid
//   sel, load     source index and load request (sampled in IDLE only)
//   clear_error   clears the sticky error state
//   acc_out       accumulator register; acc_zero/acc_neg are derived from it
//   busy          high in WAIT
//   done          one-cycle pulse after a capture
//   sel_error     sticky error flag; err_code holds the first error
//                 (01 bad select, 10 timeout)
module acc_src_select #(
  parameter int unsigned DATA_WIDTH = 11,
  parameter int unsigned NUM_INPUTS = 4,
  parameter int unsigned SEL_WIDTH  = $clog2(NUM_INPUTS),
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] src_bus,
  input  logic [NUM_INPUTS-1:0]            src_valid,
  input  logic [SEL_WIDTH-1:0]             sel,
  input  logic                             load,
  input  logic                             clear_error,
  output logic [DATA_WIDTH-1:0]            acc_out,
  output logic                             acc_zero,
  output logic                             acc_neg,
  output logic                             busy,
  output logic                             done,
  output logic                             sel_error,
  output logic [1:0]                       err_code
);

  localparam logic [SEL_WIDTH:0] NumInputsExt = (SEL_WIDTH + 1)'(NUM_INPUTS);
  localparam logic [7:0]         TimeoutCnt   = 8'(TIMEOUT);

  localparam logic [1:0] ErrNone    = 2'b00;
  localparam logic [1:0] ErrBadSel  = 2'b01;
  localparam logic [1:0] ErrTimeout = 2'b10;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  acc_q, acc_d;
  logic [SEL_WIDTH-1:0]   sel_q, sel_d;
  logic [7:0]             cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic [1:0]             code_q, code_d;

  logic [SEL_WIDTH-1:0]   idx;
  logic [DATA_WIDTH-1:0]  idx_data;
  logic                   idx_valid;
  logic                   sel_bad;
  logic [7:0]             cnt_inc;
  logic                   new_err;
  logic [1:0]             new_code;

  // In WAIT the live sel input is ignored; only the latched index matters.
  assign idx     = (state_q == StWait) ? sel_q : sel;
  assign sel_bad = {1'b0, sel} >= NumInputsExt;
  assign cnt_inc = cnt_q + 8'd1;

  // Loop-based mux so an out-of-range index never slices past the bus.
  always_comb begin
    idx_data  = '0;
    idx_valid = 1'b0;
    for (int i = 0; i < int'(NUM_INPUTS); i++) begin
      if (idx == SEL_WIDTH'(i)) begin
        idx_data  = src_bus[i*DATA_WIDTH +: DATA_WIDTH];
        idx_valid = src_valid[i];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    new_err  = 1'b0;
    new_code = ErrNone;
    case (state_q)
      StIdle: begin
        if (load) begin
          if (sel_bad) begin
            new_err  = 1'b1;
            new_code = ErrBadSel;
          end else if (idx_valid) begin
            acc_d   = idx_data;
            state_d = StDone;
          end else begin
            sel_d   = sel;
            cnt_d   = '0;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (idx_valid) begin
          acc_d   = idx_data;
          state_d = StDone;
        end else if (cnt_inc == TimeoutCnt) begin
          // TIMEOUT cycles spent in WAIT with no valid: abort, no capture.
          cnt_d    = '0;
          state_d  = StIdle;
          new_err  = 1'b1;
          new_code = ErrTimeout;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // A new error beats a simultaneous clear; otherwise the first error is kept.
  always_comb begin
    err_d  = err_q;
    code_d = code_q;
    if (new_err) begin
      err_d  = 1'b1;
      code_d = (code_q == ErrNone || clear_error) ? new_code : code_q;
    end else if (clear_error) begin
      err_d  = 1'b0;
      code_d = ErrNone;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      acc_q   <= '0;
      sel_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      code_q  <= ErrNone;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      code_q  <= code_d;
    end
  end

  assign acc_out   = acc_q;
  assign acc_zero  = (acc_q == '0);
  assign acc_neg   = acc_q[DATA_WIDTH-1];
  assign busy      = (state_q == StWait);
  assign done      = (state_q == StDone);
  assign sel_error = err_q;
  assign err_code  = code_q;

endmodule

// File: tb/tb_acc_src_select.sv
// Directed bench for acc_src_select: a 4-source instance for capture and WAIT
// behaviour, a 3-source instance for select and timeout errors.
module tb_acc_src_select;

  localparam int DW = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A: NUM_INPUTS=4
  logic [4*DW-1:0] src_bus_a;
  logic [3:0]      src_valid_a;
  logic [1:0]      sel_a;
  logic            load_a, clear_a;
  logic [DW-1:0]   acc_a;
  logic            zero_a, neg_a, busy_a, done_a, err_a;
  logic [1:0]      code_a;

  // Instance B: NUM_INPUTS=3
  logic [3*DW-1:0] src_bus_b;
  logic [2:0]      src_valid_b;
  logic [1:0]      sel_b;
  logic            load_b, clear_b;
  logic [DW-1:0]   acc_b;
  logic            zero_b, neg_b, busy_b, done_b, err_b;
  logic [1:0]      code_b;

  acc_src_select #(.DATA_WIDTH(DW), .NUM_INPUTS(4), .TIMEOUT(15)) u_dut_a (
    .clk(clk), .reset(reset), .src_bus(src_bus_a), .src_valid(src_valid_a),
    .sel(sel_a), .load(load_a), .clear_error(clear_a), .acc_out(acc_a),
    .acc_zero(zero_a), .acc_neg(neg_a), .busy(busy_a), .done(done_a),
    .sel_error(err_a), .err_code(code_a)
  );

  acc_src_select #(.DATA_WIDTH(DW), .NUM_INPUTS(3), .TIMEOUT(15)) u_dut_b (
    .clk(clk), .reset(reset), .src_bus(src_bus_b), .src_valid(src_valid_b),
    .sel(sel_b), .load(load_b), .clear_error(clear_b), .acc_out(acc_b),
    .acc_zero(zero_b), .acc_neg(neg_b), .busy(busy_b), .done(done_b),
    .sel_error(err_b), .err_code(code_b)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    src_bus_a = '0; src_valid_a = '0; sel_a = '0; load_a = 1'b0; clear_a = 1'b0;
    src_bus_b = '0; src_valid_b = '0; sel_b = '0; load_b = 1'b0; clear_b = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_acc", 32'(acc_a), 32'h0);
    chk("rst_zero", 32'(zero_a), 32'h1);
    chk("rst_neg", 32'(neg_a), 32'h0);
    chk("rst_busy", 32'(busy_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_err", 32'(err_a), 32'h0);
    chk("rst_code", 32'(code_a), 32'h0);

    // Immediate captures, back-to-back loads every 2 cycles
    reset = 1'b0;
    src_bus_a = {11'h000, 11'b00000000000, 11'b00001110001, 11'b11110000010};
    src_valid_a = 4'b1111;
    load_a = 1'b1; sel_a = 2'd0;
    tick();
    chk("ld0_acc", 32'(acc_a), 32'h782);
    chk("ld0_neg", 32'(neg_a), 32'h1);
    chk("ld0_zero", 32'(zero_a), 32'h0);
    chk("ld0_done", 32'(done_a), 32'h1);
    sel_a = 2'd1;
    tick();
    chk("done_ign_acc", 32'(acc_a), 32'h782);
    chk("done_drop", 32'(done_a), 32'h0);
    tick();
    chk("ld1_acc", 32'(acc_a), 32'h071);
    chk("ld1_neg", 32'(neg_a), 32'h0);
    chk("ld1_done", 32'(done_a), 32'h1);
    sel_a = 2'd2;
    tick();
    chk("ld2_gap_done", 32'(done_a), 32'h0);
    tick();
    chk("ld2_acc", 32'(acc_a), 32'h000);
    chk("ld2_zero", 32'(zero_a), 32'h1);
    chk("ld2_done", 32'(done_a), 32'h1);
    load_a = 1'b0;
    tick();

    // Slow source: src2 valid after 3 busy cycles, load during WAIT ignored
    src_bus_a[2*DW +: DW] = 11'b10001100100;
    src_valid_a = 4'b1011;
    load_a = 1'b1; sel_a = 2'd2;
    tick();
    chk("w_busy1", 32'(busy_a), 32'h1);
    sel_a = 2'd0;
    tick();
    chk("w_busy2", 32'(busy_a), 32'h1);
    chk("w_ign_acc", 32'(acc_a), 32'h000);
    tick();
    chk("w_busy3", 32'(busy_a), 32'h1);
    chk("w_done_low", 32'(done_a), 32'h0);
    load_a = 1'b0;
    src_valid_a = 4'b1111;
    tick();
    chk("w_acc", 32'(acc_a), 32'h464);
    chk("w_busy_drop", 32'(busy_a), 32'h0);
    chk("w_done", 32'(done_a), 32'h1);
    tick();
    chk("w_done_once", 32'(done_a), 32'h0);

    // Reset during WAIT
    src_valid_a = 4'b1011;
    load_a = 1'b1; sel_a = 2'd2;
    tick();
    load_a = 1'b0;
    chk("rw_busy", 32'(busy_a), 32'h1);
    tick();
    reset = 1'b1;
    tick();
    chk("rw_busy0", 32'(busy_a), 32'h0);
    chk("rw_acc0", 32'(acc_a), 32'h000);
    chk("rw_done0", 32'(done_a), 32'h0);
    reset = 1'b0;
    src_valid_a = 4'b1111;
    tick();
    chk("rw_nocap", 32'(acc_a), 32'h000);
    chk("rw_nodone", 32'(done_a), 32'h0);

    // Bad select on the 3-source instance
    src_bus_b = {11'h055, 11'h2AA, 11'h123};
    src_valid_b = 3'b111;
    load_b = 1'b1; sel_b = 2'd3;
    tick();
    load_b = 1'b0;
    chk("bs_err", 32'(err_b), 32'h1);
    chk("bs_code", 32'(code_b), 32'h1);
    chk("bs_acc", 32'(acc_b), 32'h000);
    chk("bs_busy", 32'(busy_b), 32'h0);
    chk("bs_done", 32'(done_b), 32'h0);

    // Timeout keeps the first error code
    src_valid_b = 3'b101;
    load_b = 1'b1; sel_b = 2'd1;
    tick();
    load_b = 1'b0;
    chk("to_busy_first", 32'(busy_b), 32'h1);
    for (int i = 1; i < 15; i++) begin
      tick();
      chk("to_busy", 32'(busy_b), 32'h1);
      chk("to_no_done", 32'(done_b), 32'h0);
    end
    tick();
    chk("to_idle", 32'(busy_b), 32'h0);
    chk("to_done", 32'(done_b), 32'h0);
    chk("to_acc", 32'(acc_b), 32'h000);
    chk("to_keep_code", 32'(code_b), 32'h1);

    // Clear
    clear_b = 1'b1;
    tick();
    clear_b = 1'b0;
    chk("clr_err", 32'(err_b), 32'h0);
    chk("clr_code", 32'(code_b), 32'h0);

    // Fresh timeout reports code 10
    load_b = 1'b1; sel_b = 2'd1;
    tick();
    load_b = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("to2_busy", 32'(busy_b), 32'h0);
    chk("to2_done", 32'(done_b), 32'h0);
    chk("to2_err", 32'(err_b), 32'h1);
    chk("to2_code", 32'(code_b), 32'h2);
    chk("to2_acc", 32'(acc_b), 32'h000);

    // New error in the same cycle as clear: error wins with the new code
    load_b = 1'b1; sel_b = 2'd3; clear_b = 1'b1;
    tick();
    load_b = 1'b0; clear_b = 1'b0;
    chk("ec_err", 32'(err_b), 32'h1);
    chk("ec_code", 32'(code_b), 32'h1);

    // Valid source after errors still captures
    src_valid_b = 3'b111;
    load_b = 1'b1; sel_b = 2'd2;
    tick();
    load_b = 1'b0;
    chk("b_cap_acc", 32'(acc_b), 32'h055);
    chk("b_cap_done", 32'(done_b), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
